// File: rtl/mat_trans_nbuf_pkg.sv
// Shared FSM encodings and width helpers for the transpose frame buffer.
package mat_trans_nbuf_pkg;

    typedef enum logic {IN_IDLE, IN_BUSY} in_state_t;

    typedef enum logic [1:0] {OUT_IDLE, OUT_REQ, OUT_RD, OUT_DRAIN} out_state_t;

    function automatic int ptr_w(input int nbuf);
        return $clog2(nbuf) + 1;
    endfunction

    function automatic int addr_w(input int rows, input int cols);
        return $clog2(rows * cols);
    endfunction

endpackage

// File: rtl/mat_trans_nbuf_if.sv
// Producer and consumer burst buses of the transpose frame buffer.
interface mat_trans_nbuf_if #(
    parameter int DW = 32
);
    logic          trans_en;
    logic          in_req;
    logic          in_ack;
    logic          in_vld;
    logic [DW-1:0] in_data;
    logic          out_req;
    logic          out_ack;
    logic          out_vld;
    logic [DW-1:0] out_data;
    logic          out_last;

    modport master (
        output trans_en, in_req, in_vld, in_data, out_ack,
        input  in_ack, out_req, out_vld, out_data, out_last
    );

    modport slave (
        input  trans_en, in_req, in_vld, in_data, out_ack,
        output in_ack, out_req, out_vld, out_data, out_last
    );
endinterface

// File: rtl/mat_trans_nbuf_spram_p.sv
// Single-port RAM, write-first.
// Latency: read data registered, 1 cycle after cs.
// Backpressure: none; one access per cycle when cs is high.
module spram_p #(
    parameter int DW    = 32,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          cs,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (cs) begin
            if (we) begin
                mem[addr] <= wdata;
                rdata     <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end
endmodule

// File: rtl/mat_trans_nbuf.sv
// Ring of NBUF frame RAMs: frames in row-major, out row-major or transposed.
// Latency: out_ack sampled at T -> out_vld visible after edge T+2, N words contiguous.
// Backpressure: in_ack low while a frame is being written or all buffers are held.
module mat_trans_nbuf
    import mat_trans_nbuf_pkg::*;
#(
    parameter int DW   = 32,
    parameter int ROWS = 8,
    parameter int COLS = 8,
    parameter int NBUF = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    mat_trans_nbuf_if.slave        bus,
    output logic [ptr_w(NBUF)-1:0] buf_cnt,
    output logic                   err_stray
);
    localparam int N  = ROWS * COLS;
    localparam int PW = ptr_w(NBUF);
    localparam int BW = PW - 1;
    localparam int AW = addr_w(ROWS, COLS);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam logic [AW-1:0] A_LAST = AW'(N - 1);
    localparam logic [RW-1:0] R_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] C_LAST = CW'(COLS - 1);

    in_state_t     in_st;
    out_state_t    out_st;
    logic [PW-1:0] wptr, rptr;
    logic [NBUF-1:0] mode;
    logic [AW-1:0] waddr, raddr;
    logic          wr_q;
    logic [DW-1:0] wdat_q;
    logic [RW-1:0] r;
    logic [CW-1:0] c;
    logic          empty, full, grant, wr_en, commit, rel;
    logic          rd, rd_last, rd_tr, rd_q, rd_last_q;
    logic [DW-1:0] rdata [NBUF];

    assign empty      = (wptr == rptr);
    assign full       = (wptr[PW-1] != rptr[PW-1]) && (wptr[BW-1:0] == rptr[BW-1:0]);
    assign bus.in_ack = (in_st == IN_IDLE) && !full;
    assign grant      = bus.in_ack && bus.in_req;
    assign wr_en      = (in_st == IN_BUSY) && wr_q;
    assign commit     = wr_en && (waddr == A_LAST);
    assign rel        = (out_st == OUT_DRAIN) && bus.out_last;
    assign rd         = (out_st == OUT_RD);
    assign rd_last    = rd && (r == R_LAST) && (c == C_LAST);
    assign rd_tr      = mode[rptr[BW-1:0]];
    assign raddr      = AW'(r * COLS) + AW'(c);

    always_ff @(posedge clk) begin
        if (rst) begin
            in_st     <= IN_IDLE;
            wptr      <= '0;
            waddr     <= '0;
            wr_q      <= 1'b0;
            err_stray <= 1'b0;
        end else begin
            wr_q      <= bus.in_vld && (in_st == IN_BUSY);
            err_stray <= bus.in_vld && (in_st == IN_IDLE);
            case (in_st)
                IN_IDLE: if (grant) begin
                    in_st <= IN_BUSY;
                    waddr <= '0;
                end
                IN_BUSY: if (wr_q) begin
                    waddr <= waddr + 1'b1;
                    if (waddr == A_LAST) begin
                        wptr  <= wptr + 1'b1;
                        in_st <= IN_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        wdat_q       <= bus.in_data;
        bus.out_data <= rdata[rptr[BW-1:0]];
        if (grant)
            mode[wptr[BW-1:0]] <= bus.trans_en;
    end

    // Both modes walk the same r/c counters; only which one runs fastest differs.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_st       <= OUT_IDLE;
            bus.out_req  <= 1'b0;
            bus.out_vld  <= 1'b0;
            bus.out_last <= 1'b0;
            rd_q         <= 1'b0;
            rd_last_q    <= 1'b0;
            rptr         <= '0;
            buf_cnt      <= '0;
            r            <= '0;
            c            <= '0;
        end else begin
            rd_q         <= rd;
            rd_last_q    <= rd_last;
            bus.out_vld  <= rd_q;
            bus.out_last <= rd_last_q;
            buf_cnt      <= buf_cnt + PW'(commit) - PW'(rel);
            case (out_st)
                OUT_IDLE: if (!empty) begin
                    out_st      <= OUT_REQ;
                    bus.out_req <= 1'b1;
                end
                OUT_REQ: if (bus.out_ack) begin
                    out_st      <= OUT_RD;
                    bus.out_req <= 1'b0;
                    r           <= '0;
                    c           <= '0;
                end
                OUT_RD: begin
                    if (rd_tr) begin
                        if (r == R_LAST) begin
                            r <= '0;
                            c <= c + 1'b1;
                        end else begin
                            r <= r + 1'b1;
                        end
                    end else begin
                        if (c == C_LAST) begin
                            c <= '0;
                            r <= r + 1'b1;
                        end else begin
                            c <= c + 1'b1;
                        end
                    end
                    if (rd_last)
                        out_st <= OUT_DRAIN;
                end
                OUT_DRAIN: if (bus.out_last) begin
                    rptr   <= rptr + 1'b1;
                    out_st <= OUT_IDLE;
                end
            endcase
        end
    end

    for (genvar i = 0; i < NBUF; i++) begin : g_buf
        logic we_i, rd_i;
        assign we_i = wr_en && (wptr[BW-1:0] == BW'(i));
        assign rd_i = rd && (rptr[BW-1:0] == BW'(i));
        spram_p #(.DW(DW), .DEPTH(N)) u_ram (
            .clk   (clk),
            .cs    (we_i | rd_i),
            .we    (we_i),
            .addr  (we_i ? waddr : raddr),
            .wdata (wdat_q),
            .rdata (rdata[i])
        );
    end
endmodule
